// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between IFU (read-only) and LSU (read/write).
// Fixed LSU priority by default; define ARB_RR_EN for round-robin arbitration on ties.
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // IFU
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_resp_valid,
  input  logic            ifu_resp_ready,
  output logic [DW-1:0]   ifu_rdata,
  output logic            ifu_resp_err,
  // LSU
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  output logic            lsu_resp_valid,
  input  logic            lsu_resp_ready,
  output logic [DW-1:0]   lsu_rdata,
  output logic            lsu_resp_err,
  // Memory slave
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_resp_valid,
  output logic            mem_resp_ready,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_resp_err,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e state_q, state_d;
  logic   own_q, own_d;  // 0 = IFU, 1 = LSU
  logic   winner;
  logic   req_hs, resp_hs;

`ifdef ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // On a tie, favour whoever was not granted last.
  always_comb begin
    if (ifu_req_valid && lsu_req_valid) begin
      winner = ~last_grant_q;
    end else begin
      winner = lsu_req_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign winner = lsu_req_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
    end
  end

  assign req_hs  = (state_q == StReq) && mem_req_ready &&
                   (own_q ? lsu_req_valid : ifu_req_valid);
  assign resp_hs = (state_q == StResp) && mem_resp_valid &&
                   (own_q ? lsu_resp_ready : ifu_resp_ready);
  assign busy    = (state_q != StIdle);

  always_comb begin
    state_d        = state_q;
    own_d          = own_q;
`ifdef ARB_RR_EN
    last_grant_d   = last_grant_q;
`endif
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    ifu_resp_err   = 1'b0;
    lsu_resp_err   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_addr       = '0;
    mem_wen        = 1'b0;
    mem_wdata      = '0;
    mem_wstrb      = '0;
    mem_resp_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ifu_req_valid || lsu_req_valid) begin
          own_d        = winner;
          state_d      = StReq;
`ifdef ARB_RR_EN
          last_grant_d = winner;
`endif
        end
      end
      StReq: begin
        if (own_q) begin
          mem_req_valid = lsu_req_valid;
          lsu_req_ready = mem_req_ready;
          mem_addr      = lsu_addr;
          mem_wen       = lsu_wen;
          mem_wdata     = lsu_wdata;
          mem_wstrb     = lsu_wstrb;
        end else begin
          mem_req_valid = ifu_req_valid;
          ifu_req_ready = mem_req_ready;
          mem_addr      = ifu_addr;
        end
        if (req_hs) state_d = StResp;
      end
      StResp: begin
        if (own_q) begin
          lsu_resp_valid = mem_resp_valid;
          lsu_rdata      = mem_rdata;
          lsu_resp_err   = mem_resp_err;
          mem_resp_ready = lsu_resp_ready;
        end else begin
          ifu_resp_valid = mem_resp_valid;
          ifu_rdata      = mem_rdata;
          ifu_resp_err   = mem_resp_err;
          mem_resp_ready = ifu_resp_ready;
        end
        if (resp_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle-by-cycle vector table plus directed sequences
// for reset recovery and (with ARB_RR_EN) round-robin alternation.
module tb_mem_arbiter;

  localparam logic [31:0] IfuA = 32'h8000_0000;
  localparam logic [31:0] LsuA = 32'h8000_1000;
  localparam logic [31:0] Wd   = 32'hDEAD_BEEF;
  localparam logic [31:0] Rd   = 32'h0000_0413;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic        lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wstrb, mem_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic        mem_resp_err, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_rdata      (ifu_rdata),
    .ifu_resp_err   (ifu_resp_err),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wstrb      (lsu_wstrb),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_ready (lsu_resp_ready),
    .lsu_rdata      (lsu_rdata),
    .lsu_resp_err   (lsu_resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_rdata      (mem_rdata),
    .mem_resp_err   (mem_resp_err),
    .busy           (busy)
  );

  // in  = {ifu_v, lsu_v, lsu_wen, mem_req_ready, mem_resp_valid, mem_resp_err, ifu_rr, lsu_rr}
  // exp = {busy, mem_req_valid, mem_wen, ifu_req_ready, lsu_req_ready,
  //        ifu_resp_valid, lsu_resp_valid, mem_resp_ready, ifu_resp_err, lsu_resp_err}
  // d   = data view: 0 none, 1 IFU request, 2 LSU request, 3 IFU response, 4 LSU response
  typedef struct {
    logic [7:0] in;
    logic [9:0] exp;
    int         d;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] in);
    {ifu_req_valid, lsu_req_valid, lsu_wen, mem_req_ready,
     mem_resp_valid, mem_resp_err, ifu_resp_ready, lsu_resp_ready} = in;
  endtask

  function automatic logic [9:0] ctl();
    return {busy, mem_req_valid, mem_wen, ifu_req_ready, lsu_req_ready,
            ifu_resp_valid, lsu_resp_valid, mem_resp_ready, ifu_resp_err, lsu_resp_err};
  endfunction

  task automatic chk_data(input string name, input int d);
    logic [31:0] ea, ew, eir, elr;
    logic [3:0]  es;
    ea = '0; ew = '0; es = '0; eir = '0; elr = '0;
    case (d)
      1: ea = IfuA;
      2: begin ea = LsuA; ew = Wd; es = 4'hF; end
      3: eir = Rd;
      4: elr = Rd;
      default: ;
    endcase
    chk({name, " data"}, {mem_addr, mem_wdata, mem_wstrb, ifu_rdata, lsu_rdata},
        {ea, ew, es, eir, elr});
  endtask

  initial begin
    rst = 1'b1;
    drive(8'h00);
    ifu_addr  = IfuA;
    lsu_addr  = LsuA;
    lsu_wdata = Wd;
    lsu_wstrb = 4'hF;
    mem_rdata = Rd;

    // IFU read
    vecs.push_back('{8'b10010000, 10'b0000000000, 0});
    vecs.push_back('{8'b10010000, 10'b1101000000, 1});
    vecs.push_back('{8'b00001010, 10'b1000010100, 3});
    vecs.push_back('{8'b00000000, 10'b0000000000, 0});
    // LSU write
    vecs.push_back('{8'b01110000, 10'b0000000000, 0});
    vecs.push_back('{8'b01110000, 10'b1110100000, 2});
    vecs.push_back('{8'b00001001, 10'b1000001100, 4});
    vecs.push_back('{8'b00000000, 10'b0000000000, 0});
    // Simultaneous requests
    vecs.push_back('{8'b11010000, 10'b0000000000, 0});
`ifdef ARB_RR_EN
    // LSU was granted last, so the IFU wins this tie
    vecs.push_back('{8'b11010000, 10'b1101000000, 1});
    vecs.push_back('{8'b01001010, 10'b1000010100, 3});
    vecs.push_back('{8'b01010000, 10'b0000000000, 0});
    vecs.push_back('{8'b01010000, 10'b1100100000, 2});
    vecs.push_back('{8'b00001001, 10'b1000001100, 4});
`else
    vecs.push_back('{8'b11010000, 10'b1100100000, 2});
    vecs.push_back('{8'b10001001, 10'b1000001100, 4});
    vecs.push_back('{8'b10010000, 10'b0000000000, 0});
    vecs.push_back('{8'b10010000, 10'b1101000000, 1});
    vecs.push_back('{8'b00001010, 10'b1000010100, 3});
`endif
    vecs.push_back('{8'b00000000, 10'b0000000000, 0});
    // LSU read, slave stalls 4 cycles, early resp ignored, then error response
    vecs.push_back('{8'b01000000, 10'b0000000000, 0});
    for (int i = 0; i < 4; i++) vecs.push_back('{8'b11001000, 10'b1100000000, 2});
    vecs.push_back('{8'b11010000, 10'b1100100000, 2});
    vecs.push_back('{8'b10001100, 10'b1000001001, 4});
    vecs.push_back('{8'b10001101, 10'b1000001101, 4});
    vecs.push_back('{8'b10010000, 10'b0000000000, 0});
    vecs.push_back('{8'b10010000, 10'b1101000000, 1});
    vecs.push_back('{8'b00001010, 10'b1000010100, 3});
    vecs.push_back('{8'b00000000, 10'b0000000000, 0});

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk("reset ctl", ctl(), 10'b0);
    chk_data("reset", 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].in);
      #2;
      chk($sformatf("vec%0d ctl", i), ctl(), vecs[i].exp);
      chk_data($sformatf("vec%0d", i), vecs[i].d);
    end

    // Reset while in RESP
    @(negedge clk); drive(8'b01010000);
    @(negedge clk); drive(8'b01010000);
    @(negedge clk); drive(8'b00000001); #2;
    chk("pre-reset resp", ctl(), 10'b1000000100);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; drive(8'b00000000); #2;
    chk("post-reset ctl", ctl(), 10'b0);
    chk_data("post-reset", 0);
    @(negedge clk); drive(8'b10010000); #2;
    chk("fresh idle", ctl(), 10'b0);
    @(negedge clk); #2;
    chk("fresh req", ctl(), 10'b1101000000);
    chk_data("fresh req", 1);
    @(negedge clk); drive(8'b00001010); #2;
    chk("fresh resp", ctl(), 10'b1000010100);
    chk_data("fresh resp", 3);
    @(negedge clk); drive(8'b00000000); #2;
    chk("fresh done", ctl(), 10'b0);

`ifdef ARB_RR_EN
    // Continuous contention after reset: grants alternate L, I, L, I, L, I
    for (int t = 0; t < 6; t++) begin
      logic el;
      el = ((t % 2) == 0);
      @(negedge clk); drive(8'b11011011); #2;
      chk($sformatf("rr%0d idle", t), {29'b0, busy, mem_req_valid, mem_resp_ready}, 128'd0);
      @(negedge clk); #2;
      chk($sformatf("rr%0d grant", t), {mem_req_valid, lsu_req_ready, ifu_req_ready},
          {1'b1, el, ~el});
      @(negedge clk); #2;
      chk($sformatf("rr%0d resp", t), {lsu_resp_valid, ifu_resp_valid}, {el, ~el});
    end
    @(negedge clk); drive(8'b00000000);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
